// File: rtl/auth_attempt_guard_if.sv
// rtl/auth_attempt_guard_if.sv - request, comparator and response signals of the authentication guard
interface auth_attempt_guard_if #(
    parameter int HASH_W = 32
);
    logic              req_valid;
    logic              req_ready;
    logic [HASH_W-1:0] req_hash;
    logic              cmp_request;
    logic [HASH_W-1:0] cmp_hash;
    logic              cmp_result;
    logic              resp_valid;
    logic              resp_grant;
    logic              resp_ready;
    logic              locked;
    logic [3:0]        fail_count;

    modport master (
        output req_valid, req_hash, cmp_result, resp_ready,
        input  req_ready, cmp_request, cmp_hash, resp_valid, resp_grant, locked, fail_count
    );

    modport slave (
        input  req_valid, req_hash, cmp_result, resp_ready,
        output req_ready, cmp_request, cmp_hash, resp_valid, resp_grant, locked, fail_count
    );
endinterface

// File: rtl/auth_attempt_guard.sv
// rtl/auth_attempt_guard.sv - constant-time request sequencer with fail counting; lockout under AUTH_GUARD_LOCKOUT_EN
module auth_attempt_guard #(
    parameter int HASH_W         = 32,
    parameter int CMP_LATENCY    = 2,
    parameter int RESP_LATENCY   = 16,
    parameter int MAX_FAILS      = 3,
    parameter int LOCKOUT_CYCLES = 1024
) (
    input logic                  clk,
    input logic                  reset_n,
    auth_attempt_guard_if.slave  bus
);

    localparam int CNT_MAX = (LOCKOUT_CYCLES > RESP_LATENCY) ? LOCKOUT_CYCLES : RESP_LATENCY;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    // Counter reads k-1 during cycle k after the accept edge.
    localparam logic [CNT_W-1:0] SAMPLE_AT = CNT_W'(CMP_LATENCY);
    localparam logic [CNT_W-1:0] RESP_AT   = CNT_W'(RESP_LATENCY - 2);

`ifdef AUTH_GUARD_LOCKOUT_EN
    localparam logic [CNT_W-1:0] LOCK_LAST = CNT_W'(LOCKOUT_CYCLES - 1);
    localparam logic [3:0]       FAIL_LIM  = 4'(MAX_FAILS);

    typedef enum logic [2:0] {IDLE, ISSUE, WAIT, RESPOND, LOCKOUT} state_t;
`else
    typedef enum logic [2:0] {IDLE, ISSUE, WAIT, RESPOND} state_t;
`endif

    state_t            state, state_d;
    logic [CNT_W-1:0]  cnt, cnt_d;
    logic [HASH_W-1:0] hash_q, hash_d;
    logic              flag_q, flag_d;
    logic [3:0]        fail_q, fail_d;
    logic [3:0]        fail_inc;
    logic              req_ready, cmp_request, resp_valid, resp_grant, locked;

    assign fail_inc = (fail_q == 4'd15) ? 4'd15 : fail_q + 4'd1;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state  <= IDLE;
            cnt    <= '0;
            hash_q <= '0;
            flag_q <= 1'b0;
            fail_q <= 4'd0;
        end else begin
            state  <= state_d;
            cnt    <= cnt_d;
            hash_q <= hash_d;
            flag_q <= flag_d;
            fail_q <= fail_d;
        end
    end

    always_comb begin
        state_d     = state;
        cnt_d       = cnt;
        hash_d      = hash_q;
        flag_d      = flag_q;
        fail_d      = fail_q;
        req_ready   = 1'b0;
        cmp_request = 1'b0;
        resp_valid  = 1'b0;
        resp_grant  = 1'b0;
        locked      = 1'b0;
        case (state)
            IDLE: begin
                req_ready = 1'b1;
                if (bus.req_valid) begin
                    hash_d  = bus.req_hash;
                    cnt_d   = '0;
                    flag_d  = 1'b0;
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                cmp_request = 1'b1;
                cnt_d       = cnt + 1'b1;
                state_d     = WAIT;
            end
            WAIT: begin
                // Only the one cycle the comparator is specified to answer in is observed.
                cnt_d = cnt + 1'b1;
                if (cnt == SAMPLE_AT) flag_d = bus.cmp_result;
                if (cnt == RESP_AT) state_d = RESPOND;
            end
            RESPOND: begin
                resp_valid = 1'b1;
                resp_grant = flag_q;
                if (bus.resp_ready) begin
                    hash_d  = '0;
                    cnt_d   = '0;
                    state_d = IDLE;
                    if (flag_q) begin
                        fail_d = 4'd0;
                    end else begin
                        fail_d = fail_inc;
`ifdef AUTH_GUARD_LOCKOUT_EN
                        if (fail_inc == FAIL_LIM) state_d = LOCKOUT;
`endif
                    end
                end
            end
`ifdef AUTH_GUARD_LOCKOUT_EN
            LOCKOUT: begin
                locked = 1'b1;
                cnt_d  = cnt + 1'b1;
                if (cnt == LOCK_LAST) begin
                    cnt_d   = '0;
                    fail_d  = 4'd0;
                    state_d = IDLE;
                end
            end
`endif
            default: state_d = IDLE;
        endcase
    end

    assign bus.req_ready   = req_ready;
    assign bus.cmp_request = cmp_request;
    assign bus.cmp_hash    = hash_q;
    assign bus.resp_valid  = resp_valid;
    assign bus.resp_grant  = resp_grant;
    assign bus.locked      = locked;
    assign bus.fail_count  = fail_q;

endmodule

// File: tb/tb_auth_attempt_guard.sv
// tb/tb_auth_attempt_guard.sv - randomized bench for auth_attempt_guard against a transaction-level model
module tb_auth_attempt_guard;

    localparam int HASH_W    = 32;
    localparam int CMP_LAT   = 2;
    localparam int RESP_LAT  = 16;
    localparam int MAX_FAILS = 3;
    localparam int LOCK_CYC  = 1024;
`ifdef AUTH_GUARD_LOCKOUT_EN
    localparam bit LOCK_EN = 1'b1;
`else
    localparam bit LOCK_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    auth_attempt_guard_if #(.HASH_W(HASH_W)) bus();

    auth_attempt_guard #(
        .HASH_W(HASH_W), .CMP_LATENCY(CMP_LAT), .RESP_LATENCY(RESP_LAT),
        .MAX_FAILS(MAX_FAILS), .LOCKOUT_CYCLES(LOCK_CYC)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .bus(bus)
    );

    int checks = 0;
    int failures = 0;
    int model_fails = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_outputs(input string pfx);
        check({pfx, "_req_ready"}, bus.req_ready, 1);
        check({pfx, "_cmp_request"}, bus.cmp_request, 0);
        check({pfx, "_cmp_hash"}, bus.cmp_hash, 0);
        check({pfx, "_resp_valid"}, bus.resp_valid, 0);
        check({pfx, "_resp_grant"}, bus.resp_grant, 0);
        check({pfx, "_locked"}, bus.locked, 0);
        check({pfx, "_fail_count"}, bus.fail_count, 0);
    endtask

    task automatic pulse_reset();
        reset_n = 1'b0;
        bus.req_valid = 1'b0;
        bus.cmp_result = 1'b0;
        bus.resp_ready = 1'b0;
        step();
        reset_n = 1'b1;
        model_fails = 0;
    endtask

    // Watch a lockout window: its length, req_ready staying low, and the release state.
    task automatic watch_lockout(input string pfx);
        int n = 0;
        logic ready_seen = 1'b0;
        while (bus.locked && n < LOCK_CYC + 16) begin
            if (bus.req_ready) ready_seen = 1'b1;
            bus.req_valid = 1'($urandom_range(0, 1));
            step();
            n++;
        end
        bus.req_valid = 1'b0;
        check({pfx, "_lock_len"}, n, LOCK_CYC);
        check({pfx, "_ready_in_lock"}, ready_seen, 0);
        check({pfx, "_ready_after"}, bus.req_ready, 1);
        check({pfx, "_fail_after"}, bus.fail_count, 0);
        model_fails = 0;
    endtask

    // mode: 0 deny, 1 grant, 2 result pulsed in cycles 2 and 4 only, 3 fully random
    task automatic run_txn(input logic [31:0] h, input int mode, input int bp);
        int k;
        logic v;
        logic exp_grant = 1'b0;
        logic extra_req = 1'b0;
        logic busy_ready = 1'b0;
        logic stable = 1'b1;
        logic lock_exp;

        check("accept_ready", bus.req_ready, 1);
        bus.req_valid = 1'b1;
        bus.req_hash = h;
        bus.cmp_result = 1'($urandom_range(0, 1));
        bus.resp_ready = 1'($urandom_range(0, 1));
        step();
        bus.req_hash = $urandom;
        check("cmp_request_c1", bus.cmp_request, 1);
        check("cmp_hash_c1", bus.cmp_hash, h);
        k = 1;
        while (!bus.resp_valid && k < RESP_LAT + 8) begin
            if (k >= 2 && bus.cmp_request) extra_req = 1'b1;
            if (bus.req_ready) busy_ready = 1'b1;
            case (mode)
                0: v = (k == 1 + CMP_LAT) ? 1'b0 : 1'($urandom_range(0, 1));
                1: v = (k == 1 + CMP_LAT) ? 1'b1 : 1'($urandom_range(0, 1));
                2: v = (k == 2 || k == 4);
                default: v = 1'($urandom_range(0, 1));
            endcase
            if (k == 1 + CMP_LAT) exp_grant = v;
            bus.cmp_result = v;
            bus.req_valid = 1'($urandom_range(0, 1));
            bus.resp_ready = 1'($urandom_range(0, 1));
            step();
            k++;
        end
        check("resp_latency", k, RESP_LAT);
        check("resp_valid", bus.resp_valid, 1);
        check("resp_grant", bus.resp_grant, exp_grant);
        check("single_cmp_request", extra_req, 0);
        check("busy_not_ready", busy_ready, 0);
        if (!bus.resp_valid) begin
            pulse_reset();
            return;
        end

        for (int i = 0; i < bp; i++) begin
            bus.resp_ready = 1'b0;
            bus.req_valid = 1'($urandom_range(0, 1));
            bus.cmp_result = 1'($urandom_range(0, 1));
            step();
            if (bus.resp_valid !== 1'b1 || bus.resp_grant !== exp_grant || bus.req_ready !== 1'b0)
                stable = 1'b0;
        end
        if (bp > 0) check("backpressure_stable", stable, 1);

        bus.resp_ready = 1'b1;
        bus.req_valid = 1'b0;
        step();
        bus.resp_ready = 1'b0;
        model_fails = exp_grant ? 0 : ((model_fails < 15) ? model_fails + 1 : 15);
        lock_exp = LOCK_EN && !exp_grant && (model_fails == MAX_FAILS);
        check("post_resp_valid", bus.resp_valid, 0);
        check("post_cmp_hash", bus.cmp_hash, 0);
        check("post_cmp_request", bus.cmp_request, 0);
        check("fail_count", bus.fail_count, model_fails);
        check("locked", bus.locked, lock_exp);
        check("post_req_ready", bus.req_ready, !lock_exp);
        if (lock_exp) watch_lockout("lockout");
    endtask

    task automatic abort_check(input string pfx);
        logic resp_seen = 1'b0;
        check_reset_outputs(pfx);
        for (int i = 0; i < RESP_LAT + 8; i++) begin
            if (bus.resp_valid) resp_seen = 1'b1;
            step();
        end
        check({pfx, "_no_resp"}, resp_seen, 0);
    endtask

    initial begin
        bus.req_valid = 1'b0;
        bus.req_hash = '0;
        bus.cmp_result = 1'b0;
        bus.resp_ready = 1'b0;
        pulse_reset();
        check_reset_outputs("reset");

        run_txn(32'hDEADBEEF, 1, 0);
        run_txn($urandom, 0, 0);
        run_txn($urandom, 1, 0);
        run_txn($urandom, 2, 0);
        run_txn($urandom, 0, 10);

        // Reset in cycle 8 of a transaction with a nonzero fail count.
        bus.req_valid = 1'b1;
        bus.req_hash = $urandom;
        step();
        bus.req_valid = 1'b0;
        for (int i = 1; i < 8; i++) step();
        pulse_reset();
        abort_check("reset_txn");

        if (LOCK_EN) begin
            for (int i = 0; i < MAX_FAILS - 1; i++) run_txn($urandom, 0, 0);
            bus.req_valid = 1'b1;
            bus.req_hash = $urandom;
            step();
            bus.req_valid = 1'b0;
            for (int i = 1; i < RESP_LAT; i++) step();
            bus.resp_ready = 1'b1;
            step();
            bus.resp_ready = 1'b0;
            check("lock_entry", bus.locked, 1);
            for (int i = 1; i < 500; i++) step();
            check("lock_at_500", bus.locked, 1);
            pulse_reset();
            abort_check("reset_lock");
            for (int i = 0; i < MAX_FAILS; i++) run_txn($urandom, 0, 0);
        end else begin
            for (int i = 0; i < 17; i++) run_txn($urandom, 0, i % 3);
            run_txn($urandom, 1, 0);
        end

        for (int t = 0; t < 30; t++) begin
            int m;
            int bp;
            m = $urandom_range(0, 3);
            bp = ($urandom_range(0, 3) == 0) ? 10 : $urandom_range(0, 2);
            if (bus.req_ready !== 1'b1) begin
                check("idle_before_txn", bus.req_ready, 1);
                pulse_reset();
            end
            run_txn($urandom, m, bp);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
